// File: rtl/inv_mix_state_seq_pkg.sv
// rtl/inv_mix_state_seq_pkg.sv - shared AES constants, FSM encoding and xtime helper
package inv_mix_state_seq_pkg;

   localparam logic [7:0] AES_POLY  = 8'h1B;
   localparam int         NUM_COLS  = 4;
   localparam int         COL_W     = 32;
   localparam int         STATE_W   = NUM_COLS * COL_W;
   localparam int         COL_CNT_W = $clog2(NUM_COLS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Multiply by x in GF(2^8), reducing by the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/inv_mix_state_seq_inv_mix_col.sv
// rtl/inv_mix_state_seq_inv_mix_col.sv - combinational InvMixColumns on one 32-bit column
module inv_mix_state_seq_inv_mix_col
   import inv_mix_state_seq_pkg::*;
(
   input  logic [COL_W-1:0] col_in,
   output logic [COL_W-1:0] col_out
);

   logic [7:0] a  [4];
   logic [7:0] x2 [4];
   logic [7:0] x4 [4];
   logic [7:0] x8 [4];

   genvar r;
   generate
      for (r = 0; r < 4; r++) begin : g_row
         assign a[r]  = col_in[COL_W-1-8*r -: 8];
         assign x2[r] = xtime(a[r]);
         assign x4[r] = xtime(x2[r]);
         assign x8[r] = xtime(x4[r]);
         // 0E = 8^4^2, 0B = 8^2^1, 0D = 8^4^1, 09 = 8^1
         assign col_out[COL_W-1-8*r -: 8] =
              (x8[r]         ^ x4[r]         ^ x2[r])
            ^ (x8[(r+1)%4]   ^ x2[(r+1)%4]   ^ a[(r+1)%4])
            ^ (x8[(r+2)%4]   ^ x4[(r+2)%4]   ^ a[(r+2)%4])
            ^ (x8[(r+3)%4]   ^ a[(r+3)%4]);
      end
   endgenerate

endmodule

// File: rtl/inv_mix_state_seq.sv
// rtl/inv_mix_state_seq.sv - iterative InvMixColumns over a 128-bit state, one column per clock
// Optional bypass port enabled by AES_INV_MIX_BYPASS_EN.
module inv_mix_state_seq
   import inv_mix_state_seq_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] state_in,
   output logic               out_valid,
   input  logic               out_ready,
`ifdef AES_INV_MIX_BYPASS_EN
   input  logic               bypass,
`endif
   output logic [STATE_W-1:0] state_out
);

   state_e                 state_q, state_d;
   logic [COL_CNT_W-1:0]   col_cnt_q, col_cnt_d;
   logic [STATE_W-1:0]     work_q, work_d;
   logic [COL_W-1:0]       col_in, col_mixed, col_next;
`ifdef AES_INV_MIX_BYPASS_EN
   logic                   bypass_q, bypass_d;
`endif

   inv_mix_state_seq_inv_mix_col u_inv_mix_col (
      .col_in  (col_in),
      .col_out (col_mixed)
   );

   always_comb begin
      col_in = work_q[(NUM_COLS-1-int'(col_cnt_q))*COL_W +: COL_W];
`ifdef AES_INV_MIX_BYPASS_EN
      col_next = bypass_q ? col_in : col_mixed;
`else
      col_next = col_mixed;
`endif
   end

   always_comb begin
      state_d   = state_q;
      col_cnt_d = col_cnt_q;
      work_d    = work_q;
`ifdef AES_INV_MIX_BYPASS_EN
      bypass_d  = bypass_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               work_d    = state_in;
               col_cnt_d = '0;
`ifdef AES_INV_MIX_BYPASS_EN
               bypass_d  = bypass;
`endif
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            work_d[(NUM_COLS-1-int'(col_cnt_q))*COL_W +: COL_W] = col_next;
            if (col_cnt_q == COL_CNT_W'(NUM_COLS-1)) begin
               col_cnt_d = '0;
               state_d   = ST_DONE;
            end else begin
               col_cnt_d = col_cnt_q + COL_CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         col_cnt_q <= '0;
         work_q    <= '0;
`ifdef AES_INV_MIX_BYPASS_EN
         bypass_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         col_cnt_q <= col_cnt_d;
         work_q    <= work_d;
`ifdef AES_INV_MIX_BYPASS_EN
         bypass_q  <= bypass_d;
`endif
      end
   end

   // rst gates in_ready so nothing is accepted on a reset edge
   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign out_valid = (state_q == ST_DONE);
   assign state_out = work_q;

endmodule
